md_unit: RTL

Multi-cycle multiply/divide unit with HI/LO registers, sitting in the EX stage beside the ALU. It accepts mult/multu/div/divu on a single-cycle start pulse and holds MDBusy for a fixed latency. It commits the 64-bit result into HI/LO when the operation completes. It also services mthi/mtlo writes and mfhi/mflo reads. The hazard unit stalls the pipeline on MDStart | MDBusy whenever the instruction in D is any MD-class op.

---
 rtl/md_unit_pkg.sv | 24 ++
 rtl/md_calc.sv | 78 +++++++
 rtl/md_unit.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/md_unit_pkg.sv
// md_unit_pkg: shared operation codes and result bundle for the multiply/divide unit.
// The MDOp codes are shared by the decoder, the controller and md_unit.
package md_unit_pkg;

  // Operation select carried on MDOp.
  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MTHI  = 4'd5,
    MD_MTLO  = 4'd6,
    MD_MFHI  = 4'd7,
    MD_MFLO  = 4'd8
  } md_op_e;

  // Two's-complement magnitude; 0x80000000 maps onto itself, which is the
  // correct unsigned magnitude.
  function automatic logic [31:0] mag32(input logic [31:0] v);
    mag32 = v[31] ? (32'd0 - v) : v;
  endfunction

endpackage

// File: rtl/md_calc.sv
// md_calc: purely combinational arithmetic for md_unit.
// Ports:
//   MDSrcA, MDSrcB : operands (dividend/multiplicand, divisor/multiplier)
//   MDOp           : operation select (only MULT/MULTU/DIV/DIVU produce results)
//   res_hi, res_lo : 64-bit result split into HI/LO halves
//   div_by_zero    : high for DIV/DIVU with a zero divisor
module md_calc
  import md_unit_pkg::*;
(
  input  logic [31:0] MDSrcA,
  input  logic [31:0] MDSrcB,
  input  logic [3:0]  MDOp,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo,
  output logic        div_by_zero
);

  md_op_e      op_s;
  logic [63:0] prod_s_s;
  logic [63:0] prod_u_s;
  logic        b_zero_s;
  logic [31:0] b_safe_s;
  logic [31:0] abs_a_s;
  logic [31:0] abs_b_s;
  logic [31:0] sq_mag_s;
  logic [31:0] sr_mag_s;
  logic [31:0] uq_s;
  logic [31:0] ur_s;

  assign op_s     = md_op_e'(MDOp);
  // Sign-extending to 64 bits and keeping the low 64 bits of the product
  // gives the exact two's-complement signed product.
  assign prod_s_s = {{32{MDSrcA[31]}}, MDSrcA} * {{32{MDSrcB[31]}}, MDSrcB};
  assign prod_u_s = {32'd0, MDSrcA} * {32'd0, MDSrcB};
  // A zero divisor is replaced by one so the dividers never see zero; the
  // result is discarded by md_unit anyway.
  assign b_zero_s = (MDSrcB == 32'd0);
  assign b_safe_s = b_zero_s ? 32'd1 : MDSrcB;
  assign abs_a_s  = mag32(MDSrcA);
  assign abs_b_s  = mag32(b_safe_s);
  assign sq_mag_s = abs_a_s / abs_b_s;
  assign sr_mag_s = abs_a_s % abs_b_s;
  assign uq_s     = MDSrcA / b_safe_s;
  assign ur_s     = MDSrcA % b_safe_s;

  // Result select: quotient truncates toward zero, remainder follows the dividend sign.
  always_comb begin
    res_hi      = 32'd0;
    res_lo      = 32'd0;
    div_by_zero = 1'b0;
    case (op_s)
      MD_MULT: begin
        res_hi = prod_s_s[63:32];
        res_lo = prod_s_s[31:0];
      end
      MD_MULTU: begin
        res_hi = prod_u_s[63:32];
        res_lo = prod_u_s[31:0];
      end
      MD_DIV: begin
        res_lo      = (MDSrcA[31] ^ MDSrcB[31]) ? (32'd0 - sq_mag_s) : sq_mag_s;
        res_hi      = MDSrcA[31] ? (32'd0 - sr_mag_s) : sr_mag_s;
        div_by_zero = b_zero_s;
      end
      MD_DIVU: begin
        res_lo      = uq_s;
        res_hi      = ur_s;
        div_by_zero = b_zero_s;
      end
      default: begin
        res_hi      = 32'd0;
        res_lo      = 32'd0;
        div_by_zero = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit with HI/LO registers (EX stage).
// The result is computed at start, held in pending registers, and committed
// to HI/LO after a fixed busy latency.
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   MDSrcA, MDSrcB : rs / rt operands (MDSrcA also carries mthi/mtlo data)
//   MDOp           : operation select (md_op_e)
//   MDStart        : one-cycle pulse qualifying MULT/MULTU/DIV/DIVU
//   MDBusy         : registered, high while an operation is in flight
//   HI, LO         : architectural HI/LO registers
//   MDOut          : combinational mfhi/mflo read data, 0 otherwise
module md_unit
  import md_unit_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] MDSrcA,
  input  logic [31:0] MDSrcB,
  input  logic [3:0]  MDOp,
  input  logic        MDStart,
  output logic        MDBusy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MDOut
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MBUSY = 2'd1,
    ST_DBUSY = 2'd2
  } md_state_e;

  md_op_e            op_s;
  md_state_e         state_r;
  md_state_e         state_nx_s;
  logic [CNT_W-1:0]  cnt_r;
  logic [CNT_W-1:0]  cnt_nx_s;
  logic              busy_r;
  logic [31:0]       hi_r;
  logic [31:0]       lo_r;
  logic [31:0]       pend_hi_r;
  logic [31:0]       pend_lo_r;
  logic              pend_dz_r;
  logic [31:0]       res_hi_s;
  logic [31:0]       res_lo_s;
  logic              dz_s;
  logic              start_mult_s;
  logic              start_div_s;
  logic              load_pend_s;
  logic              hi_we_s;
  logic              lo_we_s;
  logic [31:0]       hi_d_s;
  logic [31:0]       lo_d_s;

  assign op_s         = md_op_e'(MDOp);
  assign start_mult_s = MDStart && ((op_s == MD_MULT) || (op_s == MD_MULTU));
  assign start_div_s  = MDStart && ((op_s == MD_DIV) || (op_s == MD_DIVU));

  md_calc u_calc (
    .MDSrcA      (MDSrcA),
    .MDSrcB      (MDSrcB),
    .MDOp        (MDOp),
    .res_hi      (res_hi_s),
    .res_lo      (res_lo_s),
    .div_by_zero (dz_s)
  );

  // State, counter and busy flag registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
      cnt_r   <= {CNT_W{1'b0}};
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      cnt_r   <= cnt_nx_s;
      busy_r  <= (state_nx_s != ST_IDLE);
    end
  end

  // Next-state and counter logic; starts are only honoured in IDLE.
  always_comb begin
    state_nx_s = state_r;
    cnt_nx_s   = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (start_mult_s) begin
          state_nx_s = ST_MBUSY;
          cnt_nx_s   = CNT_W'(MULT_CYCLES);
        end else if (start_div_s) begin
          state_nx_s = ST_DBUSY;
          cnt_nx_s   = CNT_W'(DIV_CYCLES);
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_MBUSY, ST_DBUSY: begin
        cnt_nx_s = cnt_r - CNT_W'(1);
        if (cnt_r == CNT_W'(1)) begin
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = state_r;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
        cnt_nx_s   = {CNT_W{1'b0}};
      end
    endcase
  end

  // Output decode: pending load, HI/LO write enables, and mfhi/mflo read mux.
  always_comb begin
    load_pend_s = 1'b0;
    hi_we_s     = 1'b0;
    lo_we_s     = 1'b0;
    hi_d_s      = hi_r;
    lo_d_s      = lo_r;
    case (state_r)
      ST_IDLE: begin
        load_pend_s = start_mult_s || start_div_s;
        if (op_s == MD_MTHI) begin
          hi_we_s = 1'b1;
          hi_d_s  = MDSrcA;
        end else if (op_s == MD_MTLO) begin
          lo_we_s = 1'b1;
          lo_d_s  = MDSrcA;
        end else begin
          hi_we_s = 1'b0;
          lo_we_s = 1'b0;
        end
      end
      ST_MBUSY, ST_DBUSY: begin
        // Divide-by-zero runs the full latency but leaves HI/LO untouched.
        if ((cnt_r == CNT_W'(1)) && !pend_dz_r) begin
          hi_we_s = 1'b1;
          lo_we_s = 1'b1;
          hi_d_s  = pend_hi_r;
          lo_d_s  = pend_lo_r;
        end else begin
          hi_we_s = 1'b0;
          lo_we_s = 1'b0;
        end
      end
      default: begin
        load_pend_s = 1'b0;
      end
    endcase

    case (op_s)
      MD_MFHI: MDOut = hi_r;
      MD_MFLO: MDOut = lo_r;
      default: MDOut = 32'd0;
    endcase
  end

  // Pending result captured from the operands sampled at the start edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_hi_r <= 32'd0;
      pend_lo_r <= 32'd0;
      pend_dz_r <= 1'b0;
    end else if (load_pend_s) begin
      pend_hi_r <= res_hi_s;
      pend_lo_r <= res_lo_s;
      pend_dz_r <= dz_s;
    end
  end

  // Architectural HI/LO registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi_r <= 32'd0;
      lo_r <= 32'd0;
    end else begin
      if (hi_we_s) hi_r <= hi_d_s;
      if (lo_we_s) lo_r <= lo_d_s;
    end
  end

  assign MDBusy = busy_r;
  assign HI     = hi_r;
  assign LO     = lo_r;

endmodule
